hyperram_responder: RTL and testbench
=====================================

HYPERRAM_RESPONDER -- requirements
Module: hyperram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning log2 of backing store depth in 16-bit words.
REQ-002 SHALL have parameter LATENCY, default 6, meaning initial latency in hr_ck cycles after CA; legal range 3..7.
REQ-003 SHALL have port sys_clk  in  1  meaning single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n  in  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have ports hr_ck, hr_cs_n and hr_rst_n, each in, 1 bit, meaning controller-driven HyperRAM clock, chip select (active-low) and device reset (active-low).
REQ-006 SHALL have ports hr_dq_i  in  8, hr_dq_o  out  8 and hr_dq_oe  out  1, meaning split tristate DQ bus.
REQ-007 SHALL have ports hr_rwds_i  in  1, hr_rwds_o  out  1 and hr_rwds_oe  out  1, meaning split tristate RWDS.
REQ-008 SHALL have port busy  out  1, high whenever state is not IDLE.

Function
REQ-009 SHALL register all hr_* inputs through two sys_clk flops; an hr_ck edge is a change between the last two synchronized samples; sys_clk frequency SHALL be at least 4x hr_ck.
REQ-010 SHALL implement FSM states IDLE, CA, LAT, WR, RD.
REQ-011 IDLE -> CA when synchronized hr_cs_n falls; any rising synchronized hr_cs_n SHALL force IDLE on the next cycle from every state, abandoning the burst.
REQ-012 CA: shift hr_dq_i in on each hr_ck edge; after 6 bytes (first byte = CA[47:40]), decode CA[47] read(1)/write(0), CA[46] register space, CA[45] linear(1)/wrapped(0), and word address {CA[44:16],CA[2:0]} truncated to MEM_AW bits.
REQ-013 During CA SHALL drive hr_rwds_oe=1 and hr_rwds_o=0, signalling 1x latency.
REQ-014 After CA: memory-space access SHALL enter LAT and count 2*LATENCY hr_ck edges; register-space write SHALL enter WR with zero latency; register-space read SHALL enter LAT.
REQ-015 WR: byte pairs SHALL be captured on rise (upper byte [15:8]) then fall (lower byte [7:0]); each byte is written only if hr_rwds_i sampled low with it; the word address increments after each fall edge.
REQ-016 RD: hr_dq_oe=1 and hr_rwds_oe=1; on each hr_ck edge hr_dq_o presents the next byte, upper then lower; hr_rwds_o is 1 with the upper byte and 0 with the lower (edge-aligned).
REQ-017 Address increment SHALL wrap modulo 2^MEM_AW for linear bursts, and within the aligned 16-word group for wrapped bursts.
REQ-018 hr_dq_oe and hr_rwds_oe SHALL be 0 in IDLE and WR, and SHALL drop within 2 sys_clk cycles of hr_cs_n rising.
REQ-019 Backing store SHALL be a synchronous RAM of 2^MEM_AW x 16; read data for the next word SHALL be fetched before the next rise edge, so there is no stall.

Reset
REQ-020 On sys_rst_n=0 SHALL set state=IDLE, busy=0, hr_dq_oe=0, hr_rwds_oe=0, hr_dq_o=0, hr_rwds_o=0, byte and latency counters to 0, and CR0=16'h8F1F.
REQ-021 Synchronized hr_rst_n=0 SHALL behave as reset for everything except memory contents.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Reset asserted mid-burst SHALL abort the burst with no further memory writes.

Configuration
REQ-024 Macro HYPERRAM_RESP_REGS_EN defined SHALL implement register space: ID0 at word 0 reads 16'h0C81; CR0 at word 0x800 is read/write; CR1 at word 0x801 reads 16'hFFC1.
REQ-025 Without HYPERRAM_RESP_REGS_EN, register-space reads SHALL return 16'h0000 and register-space writes SHALL be ignored, with identical timing.

Verification
REQ-026 Write CA {0x20,0x00,0x00,0x00,0x00,0x03} followed by data 0xBEEF with RWDS low -> a subsequent read at word 3 returns bytes 0xBE then 0xEF, with hr_rwds_o 1 then 0.
REQ-027 Write 0x1234 with RWDS high on the upper byte over existing 0xBEEF -> readback is 0xBE34.
REQ-028 Linear read of 3 words starting at word 2^MEM_AW-1 -> data comes from words 1023, 0, 1 (MEM_AW=10).
REQ-029 Wrapped read starting at word 0x0E for 4 words -> addresses 0x0E, 0x0F, 0x00, 0x01.
REQ-030 Deassert hr_cs_n after 1 of 4 read words -> both oe outputs are 0 within 2 cycles, busy=0, and the next CA decodes correctly.
REQ-031 With HYPERRAM_RESP_REGS_EN defined, read register word 0 -> 0x0C81; write CR0=0x8F0F then read -> 0x8F0F; without the macro, both reads -> 0x0000.

Source files
------------

// File: rtl/hyperram_responder.sv
// HyperRAM device responder: CA decode, latency, burst read/write to a 16-bit store.
// Define HYPERRAM_RESP_REGS_EN to add the ID0/CR0/CR1 register space.
module hyperram_responder #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 6
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       hr_ck,
  input  logic       hr_cs_n,
  input  logic       hr_rst_n,
  input  logic [7:0] hr_dq_i,
  output logic [7:0] hr_dq_o,
  output logic       hr_dq_oe,
  input  logic       hr_rwds_i,
  output logic       hr_rwds_o,
  output logic       hr_rwds_oe,
  output logic       busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LAT, S_WR, S_RD
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(2 * LATENCY - 1);

  state_t r_state, w_next;

  logic [1:0]  r_ck_s, r_cs_s, r_rst_s, r_rwds_s;
  logic [7:0]  r_dq_s0, r_dq_s1;
  logic        r_ck_q, r_cs_q;

  logic [2:0]        r_byte_cnt;
  logic [3:0]        r_lat_cnt;
  logic [39:0]       r_ca;
  logic              r_is_rd, r_is_reg, r_linear;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_wr_hi;
  logic              r_wr_hi_en;
  logic [7:0]        r_dq_o;
  logic              r_rwds_o, r_dq_oe, r_rwds_oe;
  logic [15:0]       r_mem [2**MEM_AW];
  logic [15:0]       r_mem_q;

  logic              w_rst;
  logic              w_ck_edge, w_ck_rise, w_ck_fall;
  logic              w_cs_fall, w_cs_rise;
  logic [47:0]       w_ca_full;
  logic [31:0]       w_ca_addr;
  logic [MEM_AW-1:0] w_addr_inc;
  logic              w_wr_go, w_rd_go, w_mem_wr;
  logic [15:0]       w_reg_rdata, w_rd_word;
  logic              w_unused;

  // Input synchronizers; the hr_rst_n path must survive its own reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_ck_s  <= 2'b00;
      r_cs_s  <= 2'b11;
      r_rst_s <= 2'b11;
      r_ck_q  <= 1'b0;
      r_cs_q  <= 1'b1;
    end else begin
      r_ck_s  <= {r_ck_s[0], hr_ck};
      r_cs_s  <= {r_cs_s[0], hr_cs_n};
      r_rst_s <= {r_rst_s[0], hr_rst_n};
      r_ck_q  <= r_ck_s[1];
      r_cs_q  <= r_cs_s[1];
    end
  end

  always_ff @(posedge sys_clk) begin
    r_dq_s0  <= hr_dq_i;
    r_dq_s1  <= r_dq_s0;
    r_rwds_s <= {r_rwds_s[0], hr_rwds_i};
  end

  assign w_rst     = !sys_rst_n || !r_rst_s[1];
  assign w_ck_edge = r_ck_s[1] ^ r_ck_q;
  assign w_ck_rise = r_ck_s[1] & ~r_ck_q;
  assign w_ck_fall = ~r_ck_s[1] & r_ck_q;
  assign w_cs_fall = r_cs_q & ~r_cs_s[1];
  assign w_cs_rise = ~r_cs_q & r_cs_s[1];

  assign w_ca_full = {r_ca, r_dq_s1};
  assign w_ca_addr = {w_ca_full[44:16], w_ca_full[2:0]};

  assign w_addr_inc = r_linear ? r_addr + 1'b1
                    : {r_addr[MEM_AW-1:4], r_addr[3:0] + 4'd1};

  assign w_wr_go  = (r_state == S_WR) && !w_cs_rise && !w_rst;
  assign w_rd_go  = (r_state == S_RD) && !w_cs_rise;
  assign w_mem_wr = w_wr_go && w_ck_fall && !r_is_reg;

  always_ff @(posedge sys_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_cs_fall) w_next = S_CA;
      S_CA: begin
        if (w_ck_edge && r_byte_cnt == 3'd5)
          w_next = (w_ca_full[46] && !w_ca_full[47]) ? S_WR : S_LAT;
      end
      S_LAT: begin
        if (w_ck_edge && r_lat_cnt == LAT_LAST)
          w_next = r_is_rd ? S_RD : S_WR;
      end
      S_WR, S_RD: ;
      default: w_next = S_IDLE;
    endcase
    if (w_cs_rise) w_next = S_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (w_rst) begin
      r_byte_cnt <= '0;
      r_lat_cnt  <= '0;
      r_ca       <= '0;
      r_is_rd    <= 1'b0;
      r_is_reg   <= 1'b0;
      r_linear   <= 1'b0;
      r_addr     <= '0;
      r_wr_hi    <= '0;
      r_wr_hi_en <= 1'b0;
      r_dq_o     <= '0;
      r_rwds_o   <= 1'b0;
      r_dq_oe    <= 1'b0;
      r_rwds_oe  <= 1'b0;
    end else begin
      r_dq_oe   <= (w_next == S_RD);
      r_rwds_oe <= (w_next == S_CA) || (w_next == S_RD);
      if (w_next != S_RD) r_rwds_o <= 1'b0;
      if (r_state == S_IDLE) begin
        r_byte_cnt <= '0;
        r_lat_cnt  <= '0;
      end
      if (r_state == S_CA && w_ck_edge) begin
        r_ca       <= w_ca_full[39:0];
        r_byte_cnt <= r_byte_cnt + 3'd1;
        if (r_byte_cnt == 3'd5) begin
          r_is_rd   <= w_ca_full[47];
          r_is_reg  <= w_ca_full[46];
          r_linear  <= w_ca_full[45];
          r_addr    <= w_ca_addr[MEM_AW-1:0];
          r_lat_cnt <= '0;
        end
      end
      if (r_state == S_LAT && w_ck_edge)
        r_lat_cnt <= r_lat_cnt + 4'd1;
      if (w_wr_go && w_ck_rise) begin
        r_wr_hi    <= r_dq_s1;
        r_wr_hi_en <= ~r_rwds_s[1];
      end
      if ((w_wr_go || w_rd_go) && w_ck_fall)
        r_addr <= w_addr_inc;
      if (w_rd_go && w_ck_rise) begin
        r_dq_o   <= w_rd_word[15:8];
        r_rwds_o <= 1'b1;
      end
      if (w_rd_go && w_ck_fall) begin
        r_dq_o   <= w_rd_word[7:0];
        r_rwds_o <= 1'b0;
      end
    end
  end

  // Store is not reset; the word at r_addr is always prefetched.
  always_ff @(posedge sys_clk) begin
    if (w_mem_wr && r_wr_hi_en) r_mem[r_addr][15:8] <= r_wr_hi;
    if (w_mem_wr && !r_rwds_s[1]) r_mem[r_addr][7:0] <= r_dq_s1;
    r_mem_q <= r_mem[r_addr];
  end

`ifdef HYPERRAM_RESP_REGS_EN
  logic [2:0]  r_reg_sel;
  logic [15:0] r_cr0;

  always_ff @(posedge sys_clk) begin
    if (w_rst) begin
      r_reg_sel <= '0;
      r_cr0     <= 16'h8F1F;
    end else begin
      if (r_state == S_CA && w_ck_edge && r_byte_cnt == 3'd5)
        r_reg_sel <= {w_ca_addr == 32'h801,
                      w_ca_addr == 32'h800,
                      w_ca_addr == 32'h000};
      if (w_wr_go && w_ck_fall && r_is_reg && r_reg_sel[1]) begin
        if (r_wr_hi_en) r_cr0[15:8] <= r_wr_hi;
        if (!r_rwds_s[1]) r_cr0[7:0] <= r_dq_s1;
      end
    end
  end

  always_comb begin
    w_reg_rdata = 16'h0000;
    unique case (1'b1)
      r_reg_sel[0]: w_reg_rdata = 16'h0C81;
      r_reg_sel[1]: w_reg_rdata = r_cr0;
      r_reg_sel[2]: w_reg_rdata = 16'hFFC1;
      default: ;
    endcase
  end
`else
  assign w_reg_rdata = 16'h0000;
`endif

  assign w_rd_word = r_is_reg ? w_reg_rdata : r_mem_q;
  assign w_unused  = ^{w_ca_full[15:3], w_ca_addr};

  assign hr_dq_o    = r_dq_o;
  assign hr_rwds_o  = r_rwds_o;
  assign hr_dq_oe   = r_dq_oe & ~r_cs_s[1];
  assign hr_rwds_oe = r_rwds_oe & ~r_cs_s[1];
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_hyperram_responder.sv
// Bench for hyperram_responder: random bursts against an array model of the store.
// Register expectations follow HYPERRAM_RESP_REGS_EN.
module tb_hyperram_responder;
  localparam int AW    = 10;
  localparam int LAT   = 6;
  localparam int DEPTH = 1 << AW;
`ifdef HYPERRAM_RESP_REGS_EN
  localparam bit REGS = 1'b1;
`else
  localparam bit REGS = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       hr_ck = 1'b0;
  logic       hr_cs_n = 1'b1;
  logic       hr_rst_n = 1'b1;
  logic [7:0] hr_dq_i = 8'h00;
  logic       hr_rwds_i = 1'b0;
  logic [7:0] hr_dq_o;
  logic       hr_dq_oe, hr_rwds_o, hr_rwds_oe, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [DEPTH];
  logic [15:0] wr_data [32];
  logic [1:0]  wr_mask [32];
  logic [15:0] rd_got [32];
  logic [1:0]  rd_rw [32];
  logic [1:0]  rd_oe [32];

  hyperram_responder #(.MEM_AW(AW), .LATENCY(LAT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .hr_ck(hr_ck), .hr_cs_n(hr_cs_n), .hr_rst_n(hr_rst_n),
    .hr_dq_i(hr_dq_i), .hr_dq_o(hr_dq_o), .hr_dq_oe(hr_dq_oe),
    .hr_rwds_i(hr_rwds_i), .hr_rwds_o(hr_rwds_o),
    .hr_rwds_oe(hr_rwds_oe), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int next_addr(input int a, input bit lin);
    if (lin) return (a + 1) % DEPTH;
    return (a / 16) * 16 + ((a + 1) % 16);
  endfunction

  task automatic ck_edge(input logic [7:0] d, input logic rw);
    hr_dq_i = d;
    hr_rwds_i = rw;
    repeat (2) @(posedge sys_clk);
    #1 hr_ck = ~hr_ck;
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_ca(input bit rd, input bit rg, input bit lin, input int addr);
    logic [31:0] a;
    logic [47:0] ca;
    a = 32'(addr);
    ca = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
    hr_cs_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 6; i++) ck_edge(ca[47 - 8 * i -: 8], 1'b0);
  endtask

  task automatic end_tx();
    hr_cs_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic write_burst(input int addr, input bit lin, input bit rg, input int n);
    int a;
    a = addr;
    send_ca(1'b0, rg, lin, addr);
    if (!rg) repeat (2 * LAT) ck_edge(8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      ck_edge(wr_data[i][15:8], wr_mask[i][1]);
      ck_edge(wr_data[i][7:0], wr_mask[i][0]);
      if (!rg) begin
        if (!wr_mask[i][1]) model[a][15:8] = wr_data[i][15:8];
        if (!wr_mask[i][0]) model[a][7:0] = wr_data[i][7:0];
        a = next_addr(a, lin);
      end
    end
    end_tx();
  endtask

  task automatic read_burst(input int addr, input bit lin, input bit rg,
                            input int n, input bit keep_cs);
    send_ca(1'b1, rg, lin, addr);
    repeat (2 * LAT) ck_edge(8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      ck_edge(8'h00, 1'b0);
      rd_got[i][15:8] = hr_dq_o;
      rd_rw[i][1] = hr_rwds_o;
      rd_oe[i][1] = hr_dq_oe & hr_rwds_oe;
      ck_edge(8'h00, 1'b0);
      rd_got[i][7:0] = hr_dq_o;
      rd_rw[i][0] = hr_rwds_o;
      rd_oe[i][0] = hr_dq_oe & hr_rwds_oe;
    end
    if (!keep_cs) end_tx();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    if (hr_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b exp 0", hr_dq_oe); end
    if (hr_rwds_oe !== 1'b0) begin errors++; $display("FAIL reset_rwds_oe: got %b exp 0", hr_rwds_oe); end
    if (hr_dq_o !== 8'h00) begin errors++; $display("FAIL reset_dq_o: got %h exp 00", hr_dq_o); end
    if (hr_rwds_o !== 1'b0) begin errors++; $display("FAIL reset_rwds_o: got %b exp 0", hr_rwds_o); end
    sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_basic();
    wr_data[0] = 16'hBEEF;
    wr_mask[0] = 2'b00;
    write_burst(3, 1'b1, 1'b0, 1);
    read_burst(3, 1'b1, 1'b0, 1, 1'b0);
    checks += 3;
    if (rd_got[0] !== 16'hBEEF) begin errors++; $display("FAIL basic_data: got %h exp BEEF", rd_got[0]); end
    if (rd_rw[0] !== 2'b10) begin errors++; $display("FAIL basic_rwds: got %b exp 10", rd_rw[0]); end
    if (rd_oe[0] !== 2'b11) begin errors++; $display("FAIL basic_oe: got %b exp 11", rd_oe[0]); end
    wr_data[0] = 16'h1234;
    wr_mask[0] = 2'b10;
    write_burst(3, 1'b1, 1'b0, 1);
    read_burst(3, 1'b1, 1'b0, 1, 1'b0);
    checks++;
    if (rd_got[0] !== 16'hBE34) begin errors++; $display("FAIL mask_data: got %h exp BE34", rd_got[0]); end
  endtask

  task automatic test_linear_wrap();
    int a;
    a = DEPTH - 1;
    for (int i = 0; i < 3; i++) begin
      wr_data[0] = 16'($urandom);
      wr_mask[0] = 2'b00;
      write_burst(a, 1'b1, 1'b0, 1);
      a = (a + 1) % DEPTH;
    end
    read_burst(DEPTH - 1, 1'b1, 1'b0, 3, 1'b0);
    a = DEPTH - 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_got[i] !== model[a]) begin
        errors++;
        $display("FAIL lin_rd word%0d: got %h exp %h", i, rd_got[i], model[a]);
      end
      a = (a + 1) % DEPTH;
    end
    for (int i = 0; i < 3; i++) begin
      wr_data[i] = 16'($urandom);
      wr_mask[i] = 2'b00;
    end
    write_burst(DEPTH - 1, 1'b1, 1'b0, 3);
    a = DEPTH - 1;
    for (int i = 0; i < 3; i++) begin
      read_burst(a, 1'b1, 1'b0, 1, 1'b0);
      checks++;
      if (rd_got[0] !== wr_data[i]) begin
        errors++;
        $display("FAIL lin_wr addr%0d: got %h exp %h", a, rd_got[0], wr_data[i]);
      end
      a = (a + 1) % DEPTH;
    end
  endtask

  task automatic test_wrapped();
    int exp_a [4];
    exp_a[0] = 'h0E; exp_a[1] = 'h0F; exp_a[2] = 'h00; exp_a[3] = 'h01;
    for (int i = 0; i < 32; i++) begin
      wr_data[i] = 16'($urandom);
      wr_mask[i] = 2'b00;
    end
    write_burst(0, 1'b1, 1'b0, 32);
    for (int i = 0; i < 4; i++) wr_data[i] = 16'($urandom);
    write_burst('h0E, 1'b0, 1'b0, 4);
    read_burst(0, 1'b1, 1'b0, 32, 1'b0);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rd_got[i] !== model[i]) begin
        errors++;
        $display("FAIL wrap_wr word%0d: got %h exp %h", i, rd_got[i], model[i]);
      end
    end
    read_burst('h0E, 1'b0, 1'b0, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_got[i] !== wr_data[i]) begin
        errors++;
        $display("FAIL wrap_rd addr%0h: got %h exp %h", exp_a[i], rd_got[i], wr_data[i]);
      end
    end
  endtask

  task automatic test_random();
    int addr, n, a;
    bit lin;
    for (int it = 0; it < 8; it++) begin
      addr = $urandom_range(0, DEPTH - 1);
      lin = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        wr_data[i] = 16'($urandom);
        wr_mask[i] = 2'b00;
      end
      write_burst(addr, lin, 1'b0, n);
      for (int i = 0; i < n; i++) begin
        wr_data[i] = 16'($urandom);
        wr_mask[i] = 2'($urandom_range(0, 3));
      end
      write_burst(addr, lin, 1'b0, n);
      read_burst(addr, lin, 1'b0, n, 1'b0);
      a = addr;
      for (int i = 0; i < n; i++) begin
        checks++;
        if ({rd_got[i], rd_rw[i], rd_oe[i]} !== {model[a], 2'b10, 2'b11}) begin
          errors++;
          $display("FAIL rand it%0d addr%0h: got %h/%b/%b exp %h/10/11",
                   it, a, rd_got[i], rd_rw[i], rd_oe[i], model[a]);
        end
        a = next_addr(a, lin);
      end
    end
  endtask

  task automatic test_abort_cs();
    read_burst(5, 1'b1, 1'b0, 1, 1'b1);
    checks++;
    if (rd_got[0] !== model[5]) begin
      errors++;
      $display("FAIL abort_word: got %h exp %h", rd_got[0], model[5]);
    end
    hr_cs_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if ({hr_dq_oe, hr_rwds_oe} !== 2'b00) begin
      errors++;
      $display("FAIL abort_oe: got %b exp 00", {hr_dq_oe, hr_rwds_oe});
    end
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
    read_burst(9, 1'b1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_got[i] !== model[9 + i]) begin
        errors++;
        $display("FAIL abort_next word%0d: got %h exp %h", i, rd_got[i], model[9 + i]);
      end
    end
  endtask

  task automatic test_reset_abort(input bit use_hr);
    int base;
    logic [15:0] nd [3];
    base = use_hr ? 'h180 : 'h100;
    for (int i = 0; i < 3; i++) begin
      wr_data[i] = 16'($urandom);
      wr_mask[i] = 2'b00;
      nd[i] = ~wr_data[i];
    end
    write_burst(base, 1'b1, 1'b0, 3);
    send_ca(1'b0, 1'b0, 1'b1, base);
    repeat (2 * LAT) ck_edge(8'h00, 1'b0);
    ck_edge(nd[0][15:8], 1'b0);
    ck_edge(nd[0][7:0], 1'b0);
    model[base] = nd[0];
    ck_edge(nd[1][15:8], 1'b0);
    if (use_hr) hr_rst_n = 1'b0;
    else sys_rst_n = 1'b0;
    ck_edge(nd[1][7:0], 1'b0);
    ck_edge(nd[2][15:8], 1'b0);
    ck_edge(nd[2][7:0], 1'b0);
    checks++;
    if ({busy, hr_dq_oe, hr_rwds_oe} !== 3'b000) begin
      errors++;
      $display("FAIL rstabort_idle hr%0d: got %b exp 000", use_hr, {busy, hr_dq_oe, hr_rwds_oe});
    end
    hr_cs_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    hr_rst_n = 1'b1;
    sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    read_burst(base, 1'b1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_got[i] !== model[base + i]) begin
        errors++;
        $display("FAIL rstabort hr%0d word%0d: got %h exp %h",
                 use_hr, i, rd_got[i], model[base + i]);
      end
    end
  endtask

  task automatic test_regs();
    logic [15:0] e;
    read_burst(0, 1'b1, 1'b1, 1, 1'b0);
    e = REGS ? 16'h0C81 : 16'h0000;
    checks++;
    if (rd_got[0] !== e) begin errors++; $display("FAIL reg_id0: got %h exp %h", rd_got[0], e); end
    read_burst('h801, 1'b1, 1'b1, 1, 1'b0);
    e = REGS ? 16'hFFC1 : 16'h0000;
    checks++;
    if (rd_got[0] !== e) begin errors++; $display("FAIL reg_cr1: got %h exp %h", rd_got[0], e); end
    read_burst('h800, 1'b1, 1'b1, 1, 1'b0);
    e = REGS ? 16'h8F1F : 16'h0000;
    checks++;
    if (rd_got[0] !== e) begin errors++; $display("FAIL reg_cr0_rst: got %h exp %h", rd_got[0], e); end
    wr_data[0] = 16'h8F0F;
    wr_mask[0] = 2'b00;
    write_burst('h800, 1'b1, 1'b1, 1);
    read_burst('h800, 1'b1, 1'b1, 1, 1'b0);
    e = REGS ? 16'h8F0F : 16'h0000;
    checks++;
    if (rd_got[0] !== e) begin errors++; $display("FAIL reg_cr0_wr: got %h exp %h", rd_got[0], e); end
    read_burst(0, 1'b1, 1'b0, 1, 1'b0);
    checks++;
    if (rd_got[0] !== model[0]) begin
      errors++;
      $display("FAIL reg_mem_untouched: got %h exp %h", rd_got[0], model[0]);
    end
    hr_rst_n = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 hr_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    read_burst('h800, 1'b1, 1'b1, 1, 1'b0);
    e = REGS ? 16'h8F1F : 16'h0000;
    checks++;
    if (rd_got[0] !== e) begin errors++; $display("FAIL reg_cr0_hrrst: got %h exp %h", rd_got[0], e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_linear_wrap();
    test_wrapped();
    test_random();
    test_abort_cs();
    test_reset_abort(1'b0);
    test_reset_abort(1'b1);
    test_regs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
